mips_multicycle_core: RTL and testbench

- Parametrised multi-cycle MIPS32 core.
- Successor to the single-cycle CPU: instruction and data memory are folded onto one shared memory port with a req/ack handshake, so wait-state memory is tolerated.
- Sequenced by a FETCH/DECODE/EXEC/MEM/WB state machine.
- Adds jump, halt, illegal-instruction and misalignment trapping, and a retired-instruction counter.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/mips_regfile.sv | 26 ++
 rtl/mips_multicycle_core.sv | 201 ++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS32 core: opcodes, functs, sequencer
// states and the small ALU used in EXEC.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return AluSub;
            FN_AND:  return AluAnd;
            FN_OR:   return AluOr;
            FN_SLT:  return AluSlt;
            default: return AluAdd;
        endcase
    endfunction

    // Wrapping arithmetic: add/sub behave as addu/subu.
    function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            AluSub:  return a - b;
            AluAnd:  return a & b;
            AluOr:   return a | b;
            AluSlt:  return {31'b0, $signed(a) < $signed(b)};
            default: return a + b;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                             (funct == FN_OR) || (funct == FN_SLT) || (funct == FN_JR);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one write port, $0 hardwired to zero.
module mips_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] regs [32];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 core sharing one req/ack memory port between fetch and lw/sw,
// with clean halt, trap on illegal encodings / misaligned accesses, and a retire counter.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             halted,
    output logic             trap,
    output logic [31:0]      pc_out,
    output logic [CNT_W-1:0] retired
);
    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d, npc_q, npc_d, ir_q, ir_d;
    logic [31:0]      a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0]      alu_q, alu_d, mdr_q, mdr_d;
    logic             trap_q, trap_d, retire;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, rf_waddr;
    logic [31:0] rs_val, rt_val, ea, rf_wdata;
    logic        rf_we;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign ea    = a_q + imm_q;

    assign rf_we    = (state_q == WB);
    assign rf_waddr = (op == OP_RTYPE) ? rd : rt;
    assign rf_wdata = (op == OP_LW) ? mdr_q : alu_q;

    mips_regfile u_regfile (
        .clock  (clock),
        .reset  (reset),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_val),
        .rdata2 (rt_val),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            npc_q     <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            trap_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        trap_d  = trap_q;
        retire  = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    npc_d   = pc_q + 32'd4;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
                // HALT_OPCODE wins even if it aliases a legal opcode.
                if (op == HALT_OPCODE) begin
                    state_d = HALT;
                end else if (!is_legal(op, funct)) begin
                    state_d = HALT;
                    trap_d  = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_d    = a_q;
                            retire  = 1'b1;
                            state_d = FETCH;
                        end else begin
                            alu_d   = alu_eval(funct_to_alu(funct), a_q, b_q);
                            state_d = WB;
                        end
                    end
                    OP_ADDI: begin
                        alu_d   = ea;
                        state_d = WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d = ea;
                        if (ea[1:0] != 2'b00) begin
                            state_d = HALT;
                            trap_d  = 1'b1;
                        end else begin
                            state_d = MEM;
                        end
                    end
                    OP_BEQ: begin
                        pc_d    = (a_q == b_q) ? npc_q + {imm_q[29:0], 2'b00} : npc_q;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    OP_J: begin
                        pc_d    = {npc_q[31:28], ir_q[25:0], 2'b00};
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    default: begin
                        state_d = HALT;
                        trap_d  = 1'b1;
                    end
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    if (op == OP_LW) begin
                        mdr_d   = mem_rdata;
                        state_d = WB;
                    end else begin
                        pc_d    = npc_q;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                pc_d    = npc_q;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase

        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    // Reset gates the request combinationally so an in-flight access is dropped at once.
    assign mem_req   = ~reset & ((state_q == FETCH) | (state_q == MEM));
    assign mem_we    = mem_req & (state_q == MEM) & (op == OP_SW);
    assign mem_addr  = !mem_req ? 32'd0 : ((state_q == FETCH) ? pc_q : alu_q);
    assign mem_wdata = mem_we ? b_q : 32'd0;

    assign halted  = (state_q == HALT);
    assign trap    = trap_q;
    assign pc_out  = pc_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: wait-state memory responder plus an ISA-level
// reference interpreter that predicts architectural results and cycle counts.
module tb_mips_multicycle_core;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] FILL   = 32'h4C00_0000;  // opcode 010011: traps if fetched
    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [5:0]  O_J = 6'b000010, O_BEQ = 6'b000100, O_ADDI = 6'b001000;
    localparam logic [5:0]  O_LW = 6'b100011, O_SW = 6'b101011;
    localparam logic [5:0]  F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0]  F_OR = 6'b100101, F_SLT = 6'b101010, F_JR = 6'b001000;

    logic        clock, reset, mem_req, mem_we, mem_ack, halted, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, retired;

    int checks = 0;
    int errors = 0;

    logic [31:0]  mem [256];
    logic [31:0]  wmem [256];
    logic [255:0] wvalid;
    logic [31:0]  acc_q [$];
    int           wait_n = 0;
    int           wcnt;
    logic         ack_block = 1'b0;

    int          run_cycles, stab_seen, stab_bad;
    logic [31:0] m_mem [256];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          m_retired, m_cycles;
    logic        m_trap;

    mips_multicycle_core #(
        .RESET_PC    (RST_PC),
        .HALT_OPCODE (6'b111111),
        .CNT_W       (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .trap      (trap),
        .pc_out    (pc_out),
        .retired   (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory responder: ack after wait_n stall cycles; DUT writes land in an overlay.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt   <= 0;
            wvalid <= '0;
            acc_q.delete();
        end else begin
            if (mem_req && !mem_ack) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    wmem[mem_addr[9:2]]   <= mem_wdata;
                    wvalid[mem_addr[9:2]] <= 1'b1;
                end else begin
                    acc_q.push_back(mem_addr);
                end
            end
        end
    end

    assign mem_ack   = mem_req && !ack_block && (wcnt >= wait_n);
    assign mem_rdata = wvalid[mem_addr[9:2]] ? wmem[mem_addr[9:2]] : mem[mem_addr[9:2]];

    function automatic logic [31:0] obs(input int i);
        return wvalid[i] ? wmem[i] : mem[i];
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'b0, rs[4:0], rt[4:0], rd[4:0], 5'b0, fn};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = FILL;
    endtask

    // ISA interpreter; cycles follow the per-class CPI table plus waits per access.
    task automatic run_model(input int waits);
        logic [31:0] ins, a, b, sx, ea, v;
        logic [5:0]  op, fn;
        int          rs, rt, rd;
        bit          done;
        for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = RST_PC; m_retired = 0; m_cycles = 0; m_trap = 1'b0; done = 1'b0;
        for (int step = 0; step < 2000 && !done; step++) begin
            ins = m_mem[m_pc[9:2]];
            op = ins[31:26]; fn = ins[5:0];
            rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
            sx = {{16{ins[15]}}, ins[15:0]};
            a = m_regs[rs]; b = m_regs[rt]; ea = a + sx;
            m_cycles += 2 + waits;
            if (op == 6'b111111) begin
                done = 1'b1;
            end else if (op == 6'd0 && fn == F_JR) begin
                m_pc = a; m_cycles += 1; m_retired++;
            end else if (op == 6'd0 && (fn == F_ADD || fn == F_SUB || fn == F_AND ||
                                        fn == F_OR || fn == F_SLT)) begin
                case (fn)
                    F_ADD:   v = a + b;
                    F_SUB:   v = a - b;
                    F_AND:   v = a & b;
                    F_OR:    v = a | b;
                    default: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                endcase
                if (rd != 0) m_regs[rd] = v;
                m_pc += 4; m_cycles += 2; m_retired++;
            end else if (op == O_ADDI) begin
                if (rt != 0) m_regs[rt] = ea;
                m_pc += 4; m_cycles += 2; m_retired++;
            end else if (op == O_LW || op == O_SW) begin
                m_cycles += 1;
                if (ea[1:0] != 2'b00) begin
                    m_trap = 1'b1; done = 1'b1;
                end else begin
                    m_cycles += 1 + waits;
                    if (op == O_LW) begin
                        if (rt != 0) m_regs[rt] = m_mem[ea[9:2]];
                        m_cycles += 1;
                    end else begin
                        m_mem[ea[9:2]] = b;
                    end
                    m_pc += 4; m_retired++;
                end
            end else if (op == O_BEQ) begin
                m_pc = (a == b) ? m_pc + 4 + (sx << 2) : m_pc + 4;
                m_cycles += 1; m_retired++;
            end else if (op == O_J) begin
                m_pc = {m_pc[31:28] + 4'(((m_pc + 4) >> 28) - (m_pc >> 28)), ins[25:0], 2'b00};
                m_cycles += 1; m_retired++;
            end else begin
                m_trap = 1'b1; done = 1'b1;
            end
        end
    endtask

    // Reset, release, then count edges until halted, watching handshake stability.
    task automatic run_prog(input int waits);
        logic        pend, pwe;
        logic [31:0] pa, pd;
        wait_n = waits; ack_block = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        run_cycles = 0; stab_seen = 0; stab_bad = 0;
        while (run_cycles < 4000) begin
            pend = mem_req && !mem_ack; pa = mem_addr; pd = mem_wdata; pwe = mem_we;
            @(posedge clock);
            #1;
            run_cycles++;
            if (pend) begin
                stab_seen++;
                if (!mem_req || mem_addr !== pa || mem_we !== pwe || mem_wdata !== pd)
                    stab_bad++;
            end
            if (halted) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks += 8;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
        if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b want 0", trap); end
        if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
        if (pc_out !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_out, RST_PC); end
    endtask

    task automatic test_arith();
        clear_mem();
        mem[0] = enc_i(O_ADDI, 0, 1, 16'd5);
        mem[1] = enc_i(O_ADDI, 0, 2, 16'hFFFD);
        mem[2] = enc_r(1, 2, 3, F_ADD);
        mem[3] = HALT_W;
        run_model(0);
        run_prog(0);
        checks += 5;
        if (halted !== 1'b1) begin errors++; $display("FAIL arith_halted: got %b want 1", halted); end
        if (trap !== 1'b0) begin errors++; $display("FAIL arith_trap: got %b want 0", trap); end
        if (retired !== 32'd3) begin errors++; $display("FAIL arith_retired: got %0d want 3", retired); end
        if (pc_out !== 32'h0C) begin errors++; $display("FAIL arith_pc: got %h want 0c", pc_out); end
        if (run_cycles != m_cycles) begin
            errors++; $display("FAIL arith_cycles: got %0d want %0d", run_cycles, m_cycles);
        end
    endtask

    task automatic test_mem_wait();
        clear_mem();
        mem[0] = enc_i(O_ADDI, 0, 1, 16'd5);
        mem[1] = enc_i(O_ADDI, 0, 2, 16'hFFFD);
        mem[2] = enc_r(1, 2, 3, F_ADD);
        mem[3] = enc_i(O_SW, 0, 3, 16'd8);
        mem[4] = enc_i(O_LW, 0, 4, 16'd8);
        mem[5] = enc_i(O_SW, 0, 4, 16'd12);
        mem[6] = HALT_W;
        run_model(2);
        run_prog(2);
        checks += 6;
        if (obs(2) !== 32'h2) begin errors++; $display("FAIL sw_data_at_8: got %h want 2", obs(2)); end
        if (obs(3) !== 32'h2) begin errors++; $display("FAIL lw_result: got %h want 2", obs(3)); end
        if (stab_bad != 0) begin errors++; $display("FAIL wait_stability: got %0d unstable want 0", stab_bad); end
        // 7 fetches + 3 data accesses, 2 stall cycles each
        if (stab_seen != 20) begin errors++; $display("FAIL wait_stalls: got %0d want 20", stab_seen); end
        if (run_cycles != m_cycles) begin
            errors++; $display("FAIL wait_cycles: got %0d want %0d", run_cycles, m_cycles);
        end
        if (retired !== 32'd6) begin errors++; $display("FAIL wait_retired: got %0d want 6", retired); end
    endtask

    task automatic test_branch_jump();
        logic [31:0] after10, after20;
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            mem[0] = enc_i(O_ADDI, 0, 1, 16'd7);
            mem[1] = enc_i(O_ADDI, 0, 2, 16'd9);
            mem[2] = enc_i(O_ADDI, 0, 0, 16'd0);
            mem[3] = enc_i(O_ADDI, 0, 0, 16'd0);
            mem[4] = enc_i(O_BEQ, 1, (pass == 0) ? 1 : 2, 16'd2);
            mem[5] = HALT_W;
            mem[7] = enc_i(O_ADDI, 0, 0, 16'd0);
            mem[8] = {O_J, 26'h40};
            mem[64] = HALT_W;
            run_model(0);
            run_prog(1);
            after10 = 32'hDEAD_BEEF; after20 = 32'hDEAD_BEEF;
            for (int i = 0; i + 1 < acc_q.size(); i++) begin
                if (acc_q[i] == 32'h10) after10 = acc_q[i + 1];
                if (acc_q[i] == 32'h20) after20 = acc_q[i + 1];
            end
            checks += 3;
            if (after10 !== ((pass == 0) ? 32'h1C : 32'h14)) begin
                errors++; $display("FAIL beq_target_%0d: got %h", pass, after10);
            end
            if (pc_out !== m_pc) begin errors++; $display("FAIL bj_pc_%0d: got %h want %h", pass, pc_out, m_pc); end
            if (retired !== 32'(m_retired)) begin
                errors++; $display("FAIL bj_retired_%0d: got %0d want %0d", pass, retired, m_retired);
            end
            if (pass == 0) begin
                checks++;
                if (after20 !== 32'h100) begin errors++; $display("FAIL j_target: got %h want 100", after20); end
            end
        end
    endtask

    task automatic test_illegal();
        int idle_bad;
        clear_mem();
        mem[0] = enc_i(O_ADDI, 0, 1, 16'd1);
        mem[1] = {6'b010011, 26'd0};
        run_prog(0);
        idle_bad = 0;
        repeat (5) begin @(negedge clock); if (mem_req) idle_bad++; end
        checks += 5;
        if (halted !== 1'b1) begin errors++; $display("FAIL ill_halted: got %b want 1", halted); end
        if (trap !== 1'b1) begin errors++; $display("FAIL ill_trap: got %b want 1", trap); end
        if (retired !== 32'd1) begin errors++; $display("FAIL ill_retired: got %0d want 1", retired); end
        if (pc_out !== 32'h4) begin errors++; $display("FAIL ill_pc: got %h want 4", pc_out); end
        if (idle_bad != 0) begin errors++; $display("FAIL ill_idle: got %0d req cycles want 0", idle_bad); end
        clear_mem();
        mem[0] = enc_r(1, 2, 3, 6'b111111);
        run_prog(0);
        checks += 2;
        if (trap !== 1'b1) begin errors++; $display("FAIL funct_trap: got %b want 1", trap); end
        if (retired !== 32'd0) begin errors++; $display("FAIL funct_retired: got %0d want 0", retired); end
    endtask

    task automatic test_misaligned();
        int idle_bad;
        clear_mem();
        mem[0] = enc_i(O_ADDI, 0, 1, 16'd2);
        mem[1] = enc_i(O_LW, 1, 2, 16'd4);
        run_model(0);
        run_prog(0);
        idle_bad = 0;
        repeat (5) begin @(negedge clock); if (mem_req) idle_bad++; end
        checks += 6;
        if (trap !== 1'b1 || halted !== 1'b1) begin
            errors++; $display("FAIL mis_trap: got halted=%b trap=%b want 1 1", halted, trap);
        end
        if (retired !== 32'd1) begin errors++; $display("FAIL mis_retired: got %0d want 1", retired); end
        if (pc_out !== 32'h4) begin errors++; $display("FAIL mis_pc: got %h want 4", pc_out); end
        if (acc_q.size() != 2) begin errors++; $display("FAIL mis_no_load: got %0d reads want 2", acc_q.size()); end
        if (idle_bad != 0) begin errors++; $display("FAIL mis_idle: got %0d req cycles want 0", idle_bad); end
        if (run_cycles != m_cycles) begin
            errors++; $display("FAIL mis_cycles: got %0d want %0d", run_cycles, m_cycles);
        end
    endtask

    task automatic test_reset_midway();
        int n;
        clear_mem();
        mem[0] = enc_i(O_ADDI, 0, 1, 16'd1);
        mem[1] = enc_i(O_ADDI, 0, 2, 16'd2);
        mem[2] = HALT_W;
        wait_n = 0; ack_block = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (!(mem_req && mem_addr == 32'h8) && n < 100) begin @(negedge clock); n++; end
        ack_block = 1'b1;
        repeat (3) @(negedge clock);
        checks += 2;
        if (n >= 100) begin errors++; $display("FAIL mid_reach: got timeout want fetch at 8"); end
        if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            errors++; $display("FAIL mid_hold: got req=%b addr=%h want 1 8", mem_req, mem_addr);
        end
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %b want 0", mem_req); end
        if (pc_out !== RST_PC) begin errors++; $display("FAIL mid_pc: got %h want %h", pc_out, RST_PC); end
        if (retired !== 32'd0) begin errors++; $display("FAIL mid_retired: got %0d want 0", retired); end
        @(negedge clock);
        ack_block = 1'b0;
        reset = 1'b0;
        n = 0;
        while (acc_q.size() == 0 && n < 50) begin @(negedge clock); n++; end
        checks++;
        if (acc_q.size() == 0) begin
            errors++; $display("FAIL mid_refetch: got no fetch want %h", RST_PC);
        end else if (acc_q[0] !== RST_PC) begin
            errors++; $display("FAIL mid_refetch: got %h want %h", acc_q[0], RST_PC);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int n, w, k, ra, rb, rc, lim;
            logic [5:0] fn;
            clear_mem();
            for (int i = 128; i < 256; i++) mem[i] = $urandom;
            n = $urandom_range(8, 20);
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 5);
                ra = $urandom_range(0, 7); rb = $urandom_range(0, 7); rc = $urandom_range(0, 7);
                case (k)
                    1: begin
                        case ($urandom_range(0, 4))
                            0: fn = F_ADD; 1: fn = F_SUB; 2: fn = F_AND; 3: fn = F_OR;
                            default: fn = F_SLT;
                        endcase
                        mem[i] = enc_r(ra, rb, rc, fn);
                    end
                    2: mem[i] = enc_i(O_SW, 0, rc, 16'(32'h300 + 4 * $urandom_range(0, 63)));
                    3: mem[i] = enc_i(O_LW, 0, rc, 16'(32'h300 + 4 * $urandom_range(0, 63)));
                    4: begin
                        lim = (n - 1 - i < 2) ? n - 1 - i : 2;
                        mem[i] = enc_i(O_BEQ, ra, rb, 16'($urandom_range(0, lim)));
                    end
                    default: mem[i] = enc_i(O_ADDI, rb, rc, 16'($urandom));
                endcase
            end
            for (int r = 0; r < 8; r++) mem[n + r] = enc_i(O_SW, 0, r, 16'(32'h200 + 4 * r));
            mem[n + 8] = HALT_W;
            w = $urandom_range(0, 3);
            run_model(w);
            run_prog(w);
            checks += 5;
            if (halted !== 1'b1 || trap !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_halt: got halted=%b trap=%b want 1 0", t, halted, trap);
            end
            if (retired !== 32'(m_retired)) begin
                errors++; $display("FAIL rnd%0d_retired: got %0d want %0d", t, retired, m_retired);
            end
            if (pc_out !== m_pc) begin errors++; $display("FAIL rnd%0d_pc: got %h want %h", t, pc_out, m_pc); end
            if (run_cycles != m_cycles) begin
                errors++; $display("FAIL rnd%0d_cycles: got %0d want %0d", t, run_cycles, m_cycles);
            end
            if (stab_bad != 0) begin errors++; $display("FAIL rnd%0d_stable: got %0d want 0", t, stab_bad); end
            for (int i = 128; i < 256; i++) begin
                if (i < 136 || i >= 192) begin
                    checks++;
                    if (obs(i) !== m_mem[i]) begin
                        errors++;
                        $display("FAIL rnd%0d_mem[%h]: got %h want %h", t, i * 4, obs(i), m_mem[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mem_wait();
        test_branch_jump();
        test_illegal();
        test_misaligned();
        test_reset_midway();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
